// File: rtl/data_port_master.sv
`default_nettype none
// ============================================================================
// Module   : data_port_master
// Purpose  : Bridges a valid/ready command stream to a req/gnt/rvalid data port.
//            Responses return on a credit-reserved valid/ready stream.
//            Optional watchdog/abort: define DATA_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_port_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_be_i,
  output logic            data_req_o,
  input  logic            data_gnt_i,
  output logic            data_we_o,
  output logic [AW-1:0]   data_addr_o,
  output logic [DW-1:0]   data_wdata_o,
  output logic [DW/8-1:0] data_be_o,
  input  logic            data_rvalid_i,
  input  logic [DW-1:0]   data_rdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_we_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            proto_err_o,
  output logic            busy_o
);

  localparam int            c_cw       = $clog2(MAX_OUT + 1);
  localparam int            c_pw       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [c_cw:0] c_max_out  = (c_cw + 1)'(MAX_OUT);
  localparam logic [c_pw-1:0] c_last_ptr = c_pw'(MAX_OUT - 1);

  if (MAX_OUT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("data_port_master: MAX_OUT and TIMEOUT must be >= 1");
  end

  function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  logic              r_cmd_en;
  logic              r_req_full;
  logic              r_req_we;
  logic [AW-1:0]     r_req_addr;
  logic [DW-1:0]     r_req_wdata;
  logic [DW/8-1:0]   r_req_be;
  logic [c_cw-1:0]   r_outstanding;
  logic [c_cw-1:0]   r_fifo_cnt;
  logic [c_pw-1:0]   r_tag_wr, r_tag_rd, r_fifo_wr, r_fifo_rd;
  logic              r_tag_q      [MAX_OUT];
  logic              r_fifo_we    [MAX_OUT];
  logic [DW-1:0]     r_fifo_rdata [MAX_OUT];
  logic              r_proto_err;

  logic              w_run, w_abort, w_credit, w_issue, w_accept, w_pop;
  logic              w_retire_ok, w_retire, w_proto;
  logic [DW-1:0]     w_push_rdata;

`ifdef DATA_MASTER_TIMEOUT_EN
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HUNG = 1'b1} state_t;
  localparam int     c_ww = $clog2(TIMEOUT + 1);
  state_t            r_state, w_state_nxt;
  logic [c_ww-1:0]   r_wd_cnt;
  logic              r_fifo_err [MAX_OUT];
  logic              w_wd_expire;

  assign w_run       = (r_state == ST_RUN);
  // Once hung, every outstanding transaction is retired as a synthesized error.
  assign w_abort     = !w_run && (r_outstanding != '0);
  assign w_wd_expire = w_run && (r_outstanding != '0) && !data_rvalid_i &&
                       (r_wd_cnt == c_ww'(TIMEOUT - 1));
  assign rsp_err_o   = rsp_valid_o & r_fifo_err[r_fifo_rd];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_RUN;
      r_wd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (data_rvalid_i || (r_outstanding == '0) || !w_run) r_wd_cnt <= '0;
      else                                                   r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && w_wd_expire) w_state_nxt = ST_HUNG;
  end

  always_ff @(posedge clk_i) begin
    if (w_retire) r_fifo_err[r_fifo_wr] <= w_abort;
  end
`else
  assign w_run     = 1'b1;
  assign w_abort   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Outstanding plus queued responses never exceeds MAX_OUT, so every grant has a FIFO slot.
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < c_max_out;
  assign data_req_o  = r_req_full & w_credit & w_run;
  assign w_issue     = data_req_o & data_gnt_i;
  assign cmd_ready_o = r_cmd_en & w_run & (!r_req_full | w_issue);
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  assign w_retire_ok = data_rvalid_i & (r_outstanding != '0) & w_run;
  assign w_retire    = w_retire_ok | w_abort;
  assign w_proto     = data_rvalid_i & !w_retire_ok;
  assign w_push_rdata = (w_retire_ok && !r_tag_q[r_tag_rd]) ? data_rdata_i : '0;

  assign data_we_o    = r_req_we;
  assign data_addr_o  = r_req_addr;
  assign data_wdata_o = r_req_wdata;
  assign data_be_o    = r_req_be;
  assign rsp_valid_o  = (r_fifo_cnt != '0);
  assign rsp_we_o     = rsp_valid_o & r_fifo_we[r_fifo_rd];
  assign rsp_rdata_o  = rsp_valid_o ? r_fifo_rdata[r_fifo_rd] : '0;
  assign proto_err_o  = r_proto_err;
  assign busy_o       = r_req_full | (r_outstanding != '0) | rsp_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd_en      <= 1'b0;
      r_req_full    <= 1'b0;
      r_req_we      <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_req_be      <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      // Command intake stays closed during and just after reset so outputs read 0.
      r_cmd_en <= 1'b1;
      if (w_accept) begin
        r_req_full  <= 1'b1;
        r_req_we    <= cmd_we_i;
        r_req_addr  <= cmd_addr_i;
        r_req_wdata <= cmd_wdata_i;
        r_req_be    <= cmd_be_i;
      end else if (w_issue) begin
        r_req_full <= 1'b0;
      end
      case ({w_issue, w_retire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: ;
      endcase
      case ({w_retire, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: ;
      endcase
      if (w_issue)  r_tag_wr  <= ptr_inc(r_tag_wr);
      if (w_retire) r_tag_rd  <= ptr_inc(r_tag_rd);
      if (w_retire) r_fifo_wr <= ptr_inc(r_fifo_wr);
      if (w_pop)    r_fifo_rd <= ptr_inc(r_fifo_rd);
      if (w_proto)  r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_issue) r_tag_q[r_tag_wr] <= r_req_we;
    if (w_retire) begin
      r_fifo_we[r_fifo_wr]    <= r_tag_q[r_tag_rd];
      r_fifo_rdata[r_fifo_wr] <= w_push_rdata;
    end
  end

endmodule
`default_nettype wire
